// File: rtl/rpn_pkg.sv
// Shared encodings for the RPN stack engine: command opcodes, ALU opcodes,
// error codes and controller states.
package rpn_pkg;

   typedef enum logic [1:0] {
      OP_PUSH  = 2'b00,
      OP_POP   = 2'b01,
      OP_ALU   = 2'b10,
      OP_CLEAR = 2'b11
   } cmd_op_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_MUL = 3'b010,
      ALU_AND = 3'b011,
      ALU_OR  = 3'b100,
      ALU_XOR = 3'b101,
      ALU_SHL = 3'b110,
      ALU_DIV = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'b00,
      ERR_UNDER = 2'b01,
      ERR_OVER  = 2'b10,
      ERR_DIV0  = 2'b11
   } err_code_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_ERROR
   } state_e;

endpackage

// File: rtl/rpn_stack.sv
// Register-array LIFO with push, pop and replace-top-two; exposes top and the
// entry beneath it. Only the entry count is reset.
module rpn_stack #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    replace,
   input  logic                    clear,
   input  logic [DATA_W-1:0]       wr_data,
   output logic [DATA_W-1:0]       rd_top,
   output logic [DATA_W-1:0]       rd_below,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     top_idx;
   logic [CW-1:0]     below_idx;

   assign top_idx   = count_q - CW'(1);
   assign below_idx = count_q - CW'(2);

   always_ff @(posedge clk) begin
      if (push)
         mem[count_q[AW-1:0]] <= wr_data;
      else if (replace)
         mem[below_idx[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         count_q <= '0;
      else if (clear)
         count_q <= '0;
      else if (push)
         count_q <= count_q + CW'(1);
      else if (pop || replace)
         count_q <= count_q - CW'(1);
   end

   // Stale array contents stay hidden: an empty stack always reads as zero.
   assign rd_top   = (count_q == '0) ? '0 : mem[top_idx[AW-1:0]];
   assign rd_below = mem[below_idx[AW-1:0]];
   assign count    = count_q;

endmodule

// File: rtl/rpn_engine.sv
// RPN calculator controller: command handshake, stack sequencing, a
// combinational ALU and a sticky error state cleared only by CLEAR.
module rpn_engine
   import rpn_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                    CLOCK_50,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_op,
   input  logic [2:0]              cmd_alu,
   input  logic [DATA_W-1:0]       cmd_data,
   output logic [DATA_W-1:0]       top,
   output logic [$clog2(DEPTH):0]  depth,
   output logic                    done,
   output logic                    err,
   output logic [1:0]              err_code
);

   localparam int CW   = $clog2(DEPTH) + 1;
   localparam int SH_W = $clog2(DATA_W);

   state_e            state_q, state_d;
   err_code_e         code_q, code_d;
   alu_op_e           op_q;
   cmd_op_e           op_in;
   logic              done_q, done_d;
   logic              accept, latch_ab;
   logic              stk_push, stk_pop, stk_replace, stk_clear;
   logic [DATA_W-1:0] a_q, b_q, res_q, alu_res;
   logic [DATA_W-1:0] rd_top, rd_below;
   logic [CW-1:0]     count;

   rpn_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_stack (
      .clk      (CLOCK_50),
      .rst_n    (rst_n),
      .push     (stk_push),
      .pop      (stk_pop),
      .replace  (stk_replace),
      .clear    (stk_clear),
      .wr_data  (stk_replace ? res_q : cmd_data),
      .rd_top   (rd_top),
      .rd_below (rd_below),
      .count    (count)
   );

   assign op_in     = cmd_op_e'(cmd_op);
   assign cmd_ready = rst_n && (state_q == S_IDLE || state_q == S_ERROR);
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      alu_res = '0;
      unique case (op_q)
         ALU_ADD: alu_res = a_q + b_q;
         ALU_SUB: alu_res = a_q - b_q;
         ALU_MUL: alu_res = a_q * b_q;
         ALU_AND: alu_res = a_q & b_q;
         ALU_OR:  alu_res = a_q | b_q;
         ALU_XOR: alu_res = a_q ^ b_q;
         ALU_SHL: alu_res = a_q << b_q[SH_W-1:0];
         ALU_DIV: alu_res = (b_q == '0) ? '0 : a_q / b_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      done_d      = 1'b0;
      latch_ab    = 1'b0;
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
      stk_replace = 1'b0;
      stk_clear   = 1'b0;
      unique case (state_q)
         S_IDLE: if (accept) begin
            unique case (op_in)
               OP_PUSH:
                  if (count == CW'(DEPTH)) begin
                     code_d  = ERR_OVER;
                     state_d = S_ERROR;
                  end else begin
                     stk_push = 1'b1;
                     done_d   = 1'b1;
                  end
               OP_POP:
                  if (count == '0) begin
                     code_d  = ERR_UNDER;
                     state_d = S_ERROR;
                  end else begin
                     stk_pop = 1'b1;
                     done_d  = 1'b1;
                  end
               OP_ALU:
                  if (count < CW'(2)) begin
                     code_d  = ERR_UNDER;
                     state_d = S_ERROR;
                  end else begin
                     latch_ab = 1'b1;
                     state_d  = S_FETCH;
                  end
               OP_CLEAR: begin
                  stk_clear = 1'b1;
                  done_d    = 1'b1;
                  code_d    = ERR_NONE;
               end
            endcase
         end
         S_FETCH: state_d = S_EXEC;
         S_EXEC:
            if (op_q == ALU_DIV && b_q == '0) begin
               code_d  = ERR_DIV0;
               state_d = S_ERROR;
            end else begin
               stk_replace = 1'b1;
               done_d      = 1'b1;
               state_d     = S_IDLE;
            end
         S_ERROR:
            if (accept && op_in == OP_CLEAR) begin
               stk_clear = 1'b1;
               done_d    = 1'b1;
               code_d    = ERR_NONE;
               state_d   = S_IDLE;
            end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         code_q  <= ERR_NONE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         done_q  <= done_d;
      end
   end

   // Operands are captured at accept; the result is registered in FETCH and
   // committed to the stack in EXEC.
   always_ff @(posedge CLOCK_50) begin
      if (latch_ab) begin
         a_q  <= rd_below;
         b_q  <= rd_top;
         op_q <= alu_op_e'(cmd_alu);
      end
      if (state_q == S_FETCH)
         res_q <= alu_res;
   end

   assign top      = rd_top;
   assign depth    = count;
   assign done     = done_q;
   assign err      = (code_q != ERR_NONE);
   assign err_code = code_q;

endmodule

// File: tb/tb_rpn_engine.sv
// Directed self-checking bench for rpn_engine (DATA_W=8, DEPTH=4) with
// hand-computed expected values.
module tb_rpn_engine;

   logic       CLOCK_50 = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [2:0] cmd_alu = 3'b000;
   logic [7:0] cmd_data = 8'd0;
   logic [7:0] top;
   logic [2:0] depth;
   logic       done;
   logic       err;
   logic [1:0] err_code;

   int tests = 0;
   int fails = 0;

   logic [2:0] t_op  [9] = '{3'b010, 3'b011, 3'b110, 3'b111, 3'b101, 3'b001, 3'b100, 3'b110, 3'b010};
   logic [7:0] t_a   [9] = '{8'd7, 8'hF0, 8'd12, 8'd100, 8'h0F, 8'd3, 8'h50, 8'd1, 8'd20};
   logic [7:0] t_b   [9] = '{8'd6, 8'h3C, 8'd3, 8'd7, 8'hFF, 8'd5, 8'h0F, 8'h0B, 8'd20};
   logic [7:0] t_exp [9] = '{8'd42, 8'h30, 8'd96, 8'd14, 8'hF0, 8'd254, 8'h5F, 8'd8, 8'd144};

   rpn_engine #(.DATA_W(8), .DEPTH(4)) dut (
      .CLOCK_50  (CLOCK_50),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_alu   (cmd_alu),
      .cmd_data  (cmd_data),
      .top       (top),
      .depth     (depth),
      .done      (done),
      .err       (err),
      .err_code  (err_code)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Returns 1 ns after the accepting edge.
   task automatic send(input logic [1:0] op, input logic [2:0] alu, input logic [7:0] d);
      int n = 0;
      @(negedge CLOCK_50);
      cmd_valid = 1'b1; cmd_op = op; cmd_alu = alu; cmd_data = d;
      while (!cmd_ready && n < 20) begin
         @(negedge CLOCK_50);
         n++;
      end
      tests++;
      if (!cmd_ready) begin
         $display("FAIL send_timeout: cmd_ready=%b required 1", cmd_ready);
         fails++;
      end
      @(posedge CLOCK_50);
      #1 cmd_valid = 1'b0;
   endtask

   // Cycle index (accept cycle = 0) at which done is seen; -1 if never.
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!done && cyc < 10) begin
         @(posedge CLOCK_50);
         #1 cyc++;
      end
      if (!done) cyc = -1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      #1;
      tests++; if (cmd_ready !== 1'b0) begin $display("FAIL rst_ready: got %b want 0", cmd_ready); fails++; end
      tests++; if (depth !== 3'd0) begin $display("FAIL rst_depth: got %0d want 0", depth); fails++; end
      tests++; if (top !== 8'd0) begin $display("FAIL rst_top: got %0d want 0", top); fails++; end
      tests++; if (done !== 1'b0 || err !== 1'b0 || err_code !== 2'b00) begin
         $display("FAIL rst_flags: done=%b err=%b code=%b want 0 0 00", done, err, err_code); fails++; end
      @(negedge CLOCK_50) rst_n = 1'b1;
      #1;
      tests++; if (cmd_ready !== 1'b1) begin $display("FAIL rst_release_ready: got %b want 1", cmd_ready); fails++; end
   endtask

   task automatic test_sub;
      int c;
      send(2'b00, 3'b000, 8'd5);
      tests++; if (done !== 1'b1 || depth !== 3'd1 || top !== 8'd5) begin
         $display("FAIL push5: done=%b depth=%0d top=%0d want 1 1 5", done, depth, top); fails++; end
      send(2'b00, 3'b000, 8'd3);
      tests++; if (depth !== 3'd2 || top !== 8'd3) begin
         $display("FAIL push3: depth=%0d top=%0d want 2 3", depth, top); fails++; end
      send(2'b10, 3'b001, 8'd0);
      wait_done(c);
      tests++; if (c !== 3) begin $display("FAIL sub_latency: got %0d want 3", c); fails++; end
      tests++; if (top !== 8'd2 || depth !== 3'd1) begin
         $display("FAIL sub_result: top=%0d depth=%0d want 2 1", top, depth); fails++; end
      @(posedge CLOCK_50); #1;
      tests++; if (done !== 1'b0) begin $display("FAIL sub_done_pulse: got %b want 0", done); fails++; end
   endtask

   task automatic test_add_wrap;
      int c;
      send(2'b11, 3'b000, 8'd0);
      send(2'b00, 3'b000, 8'd200);
      send(2'b00, 3'b000, 8'd100);
      send(2'b10, 3'b000, 8'd0);
      wait_done(c);
      tests++; if (c !== 3 || top !== 8'd44 || err !== 1'b0) begin
         $display("FAIL add_wrap: cyc=%0d top=%0d err=%b want 3 44 0", c, top, err); fails++; end
   endtask

   task automatic test_alu_ops;
      int c;
      for (int i = 0; i < 9; i++) begin
         send(2'b11, 3'b000, 8'd0);
         send(2'b00, 3'b000, t_a[i]);
         send(2'b00, 3'b000, t_b[i]);
         send(2'b10, t_op[i], 8'd0);
         wait_done(c);
         tests++; if (c !== 3 || top !== t_exp[i] || depth !== 3'd1) begin
            $display("FAIL alu_op%0d: cyc=%0d top=%0d depth=%0d want 3 %0d 1", i, c, top, depth, t_exp[i]);
            fails++;
         end
      end
   endtask

   task automatic test_underflow;
      send(2'b11, 3'b000, 8'd0);
      send(2'b10, 3'b000, 8'd0);
      tests++; if (done !== 1'b0 || err !== 1'b1 || err_code !== 2'b01 || cmd_ready !== 1'b1) begin
         $display("FAIL alu_empty: done=%b err=%b code=%b ready=%b want 0 1 01 1", done, err, err_code, cmd_ready);
         fails++; end
      send(2'b00, 3'b000, 8'd7);
      tests++; if (done !== 1'b0 || depth !== 3'd0 || err_code !== 2'b01) begin
         $display("FAIL push_in_error: done=%b depth=%0d code=%b want 0 0 01", done, depth, err_code); fails++; end
      send(2'b11, 3'b000, 8'd0);
      tests++; if (done !== 1'b1 || err !== 1'b0 || err_code !== 2'b00 || depth !== 3'd0) begin
         $display("FAIL clear_error: done=%b err=%b code=%b depth=%0d want 1 0 00 0", done, err, err_code, depth);
         fails++; end
      send(2'b01, 3'b000, 8'd0);
      tests++; if (done !== 1'b0 || err_code !== 2'b01) begin
         $display("FAIL pop_empty: done=%b code=%b want 0 01", done, err_code); fails++; end
      send(2'b11, 3'b000, 8'd0);
      send(2'b00, 3'b000, 8'd4);
      send(2'b10, 3'b000, 8'd0);
      tests++; if (err_code !== 2'b01 || depth !== 3'd1 || top !== 8'd4) begin
         $display("FAIL alu_one_entry: code=%b depth=%0d top=%0d want 01 1 4", err_code, depth, top); fails++; end
      send(2'b11, 3'b000, 8'd0);
   endtask

   task automatic test_overflow;
      for (int i = 1; i <= 4; i++) send(2'b00, 3'b000, 8'(i * 11));
      tests++; if (depth !== 3'd4 || top !== 8'd44 || err !== 1'b0) begin
         $display("FAIL fill: depth=%0d top=%0d err=%b want 4 44 0", depth, top, err); fails++; end
      send(2'b00, 3'b000, 8'd55);
      tests++; if (done !== 1'b0 || err_code !== 2'b10 || depth !== 3'd4 || top !== 8'd44) begin
         $display("FAIL overflow: done=%b code=%b depth=%0d top=%0d want 0 10 4 44", done, err_code, depth, top);
         fails++; end
      send(2'b11, 3'b000, 8'd0);
   endtask

   task automatic test_div0;
      logic saw_done;
      send(2'b00, 3'b000, 8'd9);
      send(2'b00, 3'b000, 8'd0);
      send(2'b10, 3'b111, 8'd0);
      saw_done = done;
      repeat (2) begin
         @(posedge CLOCK_50); #1;
         saw_done |= done;
      end
      tests++; if (saw_done !== 1'b0 || err !== 1'b1 || err_code !== 2'b11 || depth !== 3'd2 || top !== 8'd0) begin
         $display("FAIL div0: done=%b err=%b code=%b depth=%0d top=%0d want 0 1 11 2 0",
                  saw_done, err, err_code, depth, top); fails++; end
      send(2'b01, 3'b000, 8'd0);
      tests++; if (depth !== 3'd2 || done !== 1'b0) begin
         $display("FAIL pop_dropped: depth=%0d done=%b want 2 0", depth, done); fails++; end
      send(2'b11, 3'b000, 8'd0);
   endtask

   task automatic test_reset_fetch;
      send(2'b00, 3'b000, 8'd6);
      send(2'b00, 3'b000, 8'd7);
      send(2'b10, 3'b010, 8'd0);
      rst_n = 1'b0;
      @(posedge CLOCK_50); #1;
      tests++; if (depth !== 3'd0 || top !== 8'd0 || done !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b0) begin
         $display("FAIL rst_fetch: depth=%0d top=%0d done=%b err=%b ready=%b want 0 0 0 0 0",
                  depth, top, done, err, cmd_ready); fails++; end
      @(negedge CLOCK_50) rst_n = 1'b1;
      @(posedge CLOCK_50); #1;
      tests++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin
         $display("FAIL rst_fetch_after: done=%b ready=%b want 0 1", done, cmd_ready); fails++; end
      send(2'b00, 3'b000, 8'd8);
      tests++; if (done !== 1'b1 || depth !== 3'd1 || top !== 8'd8) begin
         $display("FAIL rst_fetch_push: done=%b depth=%0d top=%0d want 1 1 8", done, depth, top); fails++; end
      send(2'b11, 3'b000, 8'd0);
   endtask

   task automatic test_back_to_back;
      @(negedge CLOCK_50);
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'd10;
      @(posedge CLOCK_50); #1;
      tests++; if (done !== 1'b1 || depth !== 3'd1 || top !== 8'd10) begin
         $display("FAIL b2b_push1: done=%b depth=%0d top=%0d want 1 1 10", done, depth, top); fails++; end
      cmd_data = 8'd20;
      @(posedge CLOCK_50); #1;
      tests++; if (done !== 1'b1 || depth !== 3'd2 || top !== 8'd20) begin
         $display("FAIL b2b_push2: done=%b depth=%0d top=%0d want 1 2 20", done, depth, top); fails++; end
      cmd_op = 2'b01;
      @(posedge CLOCK_50); #1;
      tests++; if (done !== 1'b1 || depth !== 3'd1 || top !== 8'd10) begin
         $display("FAIL b2b_pop: done=%b depth=%0d top=%0d want 1 1 10", done, depth, top); fails++; end
      cmd_valid = 1'b0;
      @(posedge CLOCK_50); #1;
      tests++; if (done !== 1'b0 || depth !== 3'd1) begin
         $display("FAIL b2b_idle: done=%b depth=%0d want 0 1", done, depth); fails++; end
   endtask

   initial begin
      test_reset;
      test_sub;
      test_add_wrap;
      test_alu_ops;
      test_underflow;
      test_overflow;
      test_div0;
      test_reset_fetch;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
